irq_encoder16: RTL



---
 rtl/irq_pkg.sv | 26 ++
 rtl/prio_enc16.sv | 25 ++
 rtl/irq_encoder16.sv | 127 ++++++++++++
 3 files changed

// File: rtl/irq_pkg.sv
// irq_pkg: shared constants, FSM state type and helpers for the 16-line
// interrupt encoder.
//   IRQ_N          number of request lines
//   IRQ_W          width of the encoded {d,c,b,a} line number
//   irq_state_t    encoder FSM states (IDLE, PRESENT, GAP)
//   code_to_onehot turns a line number into a one-hot vector in [0:IRQ_N-1]
//                  order (bit 0 = line 0), used to clear the granted pend bit
package irq_pkg;

  localparam int IRQ_N = 16;
  localparam int IRQ_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    GAP     = 2'd2
  } irq_state_t;

  function automatic logic [0:IRQ_N-1] code_to_onehot(input logic [IRQ_W-1:0] code);
    logic [0:IRQ_N-1] vec;
    vec       = '0;
    vec[code] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/prio_enc16.sv
// prio_enc16: combinational 16-input priority encoder, lowest index wins.
//   eligible [0:15] in   candidate lines, bit i = line i
//   index    [3:0]  out  number of the lowest set line (0 when none set)
//   any             out  at least one line is set
module prio_enc16
  import irq_pkg::*;
(
  input  logic [0:IRQ_N-1] eligible,
  output logic [IRQ_W-1:0] index,
  output logic             any
);

  // Scan from the lowest-priority end so the last hit (lowest index) sticks.
  always_comb begin
    index = '0;
    for (int i = IRQ_N - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        index = IRQ_W'(i);
      end
    end
  end

  assign any = |eligible;

endmodule

// File: rtl/irq_encoder16.sv
// irq_encoder16: collects 16 active-low interrupt lines into a pending
// register, masks them, priority-encodes the winner into the {d,c,b,a} code
// and presents it to the CPU with an int_req/ack handshake.
//   clk_sys        system clock, rising edge
//   rst            synchronous active-high reset
//   irq_  [0:15]   active-low requests, bit 0 highest priority
//   mask  [0:15]   per-line grant enable (1 = eligible)
//   ack            CPU acknowledge pulse, honoured only while int_req=1
//   int_req        interrupt presented to CPU
//   a,b,c,d        registered line number, {d,c,b,a}, a = LSB
//   pend  [0:15]   pending register
// Build option: define IRQ_EDGE_EN for falling-edge request capture;
// otherwise requests are level sensitive.
module irq_encoder16
  import irq_pkg::*;
(
  input  logic             clk_sys,
  input  logic             rst,
  input  logic [0:IRQ_N-1] irq_,
  input  logic [0:IRQ_N-1] mask,
  input  logic             ack,
  output logic             int_req,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             d,
  output logic [0:IRQ_N-1] pend
);

  irq_state_t       state_reg, state_next;
  logic [0:IRQ_N-1] pend_reg, pend_next;
  logic [IRQ_W-1:0] code_reg, code_next;
  logic             int_req_reg;

  logic [0:IRQ_N-1] set_vec;
  logic [0:IRQ_N-1] clear_vec;
  logic [0:IRQ_N-1] eligible;
  logic [IRQ_W-1:0] win_index;
  logic             win_any;

`ifdef IRQ_EDGE_EN
  // Previous sample resets to all-ones so a line already low coming out of
  // reset still counts as a fresh falling edge.
  logic [0:IRQ_N-1] irq_prev_reg;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      irq_prev_reg <= '1;
    end else begin
      irq_prev_reg <= irq_;
    end
  end

  generate
    for (genvar gi = 0; gi < IRQ_N; gi++) begin : g_set_edge
      assign set_vec[gi] = irq_prev_reg[gi] & ~irq_[gi];
    end
  endgenerate
`else
  generate
    for (genvar gi = 0; gi < IRQ_N; gi++) begin : g_set_level
      assign set_vec[gi] = ~irq_[gi];
    end
  endgenerate
`endif

  assign eligible = pend_reg & mask;

  prio_enc16 u_prio_enc16 (
    .eligible (eligible),
    .index    (win_index),
    .any      (win_any)
  );

  always_comb begin
    state_next = state_reg;
    code_next  = code_reg;
    clear_vec  = '0;
    case (state_reg)
      IDLE: begin
        if (win_any) begin
          code_next  = win_index;
          state_next = PRESENT;
        end
      end
      PRESENT: begin
        // Code is frozen here: later arrivals only pend, mask changes on
        // the granted line do not withdraw the request.
        if (ack) begin
          clear_vec  = code_to_onehot(code_reg);
          state_next = GAP;
        end
      end
      GAP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Set is applied after clear so a request arriving on the grant's
    // clearing edge is retained.
    pend_next = (pend_reg & ~clear_vec) | set_vec;
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_reg   <= IDLE;
      pend_reg    <= '0;
      code_reg    <= '0;
      int_req_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pend_reg    <= pend_next;
      code_reg    <= code_next;
      int_req_reg <= (state_next == PRESENT);
    end
  end

  assign int_req = int_req_reg;
  assign pend    = pend_reg;
  assign a       = code_reg[0];
  assign b       = code_reg[1];
  assign c       = code_reg[2];
  assign d       = code_reg[3];

endmodule
